// File: rtl/serial2parallel.sv
// Deserialiser for the LSB-first framed serial stream (start/data/end strobes).
// Emits each good frame as a WIDTH-bit word with a one-cycle valid; malformed frames pulse frame_err.
module serial2parallel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_start,
  input  logic             serial_in,
  input  logic             serial_end,
  output logic [WIDTH-1:0] parallel_out,
  output logic             parallel_valid,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    pout_d  = pout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (serial_start) begin
          shreg_d[0] = serial_in;
          cnt_d      = ONE;
          state_d    = RECV;
        end else if (serial_end) begin
          err_d = 1'b1;
        end
      end
      RECV: begin
        // A restart aborts the current frame but its first bit is kept.
        if (serial_start) begin
          err_d      = 1'b1;
          shreg_d[0] = serial_in;
          cnt_d      = ONE;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (serial_end) begin
            pout_d  = {serial_in, shreg_q};
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (serial_end) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shreg_d[cnt_q] = serial_in;
          cnt_d          = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign parallel_out   = pout_q;
  assign parallel_valid = valid_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Bench for serial2parallel: directed frames plus random streams checked cycle by cycle
// against a frame-level model that collects bits in a queue.
module tb_serial2parallel;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serial_start = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_end = 1'b0;
  logic [W-1:0] parallel_out;
  logic         parallel_valid;
  logic         frame_err;

  serial2parallel #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_start  (serial_start),
    .serial_in     (serial_in),
    .serial_end    (serial_end),
    .parallel_out  (parallel_out),
    .parallel_valid(parallel_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model: frame-level view of the stream
  logic         m_in_frame = 1'b0;
  logic         mq[$];
  logic [W-1:0] m_out = '0;
  logic         m_valid = 1'b0;
  logic         m_err = 1'b0;
  int           n_valid = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    mq.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic d, input logic e);
    logic [W-1:0] word;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!m_in_frame) begin
      if (s) begin
        mq = {d};
        m_in_frame = 1'b1;
      end else if (e) m_err = 1'b1;
    end else if (s) begin
      m_err = 1'b1;
      mq = {d};
    end else if (mq.size() == W - 1) begin
      m_in_frame = 1'b0;
      if (e) begin
        mq.push_back(d);
        word = '0;
        for (int i = 0; i < W; i++) word[i] = mq[i];
        m_out   = word;
        m_valid = 1'b1;
      end else m_err = 1'b1;
    end else if (e) begin
      m_err = 1'b1;
      m_in_frame = 1'b0;
    end else mq.push_back(d);
  endtask

  task automatic cmp_outputs(input string tag);
    chk({tag, "/out"}, 32'(parallel_out), 32'(m_out));
    chk({tag, "/valid"}, 32'(parallel_valid), 32'(m_valid));
    chk({tag, "/err"}, 32'(frame_err), 32'(m_err));
    if (parallel_valid) n_valid++;
    if (frame_err) n_err++;
  endtask

  task automatic cyc(input string tag, input logic s, input logic d, input logic e);
    serial_start = s;
    serial_in    = d;
    serial_end   = e;
    @(posedge clk);
    model_step(s, d, e);
    #1;
    cmp_outputs(tag);
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) cyc(tag, i == 0, w[i], i == W - 1);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  logic [W-1:0] w;
  int           v0, e0, tv;

  initial begin
    // reset state
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_outputs("reset");
    rst_n = 1'b1;
    idle("idle0", 2);

    // 1: single A5; valid visible the cycle after bit7, then drops
    send_word("t1", 8'hA5);
    chk("t1_word", 32'(parallel_out), 32'h A5);
    chk("t1_pulse", 32'(parallel_valid), 32'd1);
    idle("t1_after", 1);
    chk("t1_onecycle", 32'(parallel_valid), 32'd0);

    // 2: back-to-back stream, pulses exactly W cycles apart
    v0 = n_valid; e0 = n_err;
    send_word("t2a", 8'h3C);
    chk("t2_3C", 32'(parallel_out), 32'h3C);
    send_word("t2b", 8'hC3);
    chk("t2_C3", 32'(parallel_out), 32'hC3);
    send_word("t2c", 8'hFF);
    chk("t2_FF", 32'(parallel_out), 32'hFF);
    chk("t2_nvalid", 32'(n_valid - v0), 32'd3);
    chk("t2_noerr", 32'(n_err - e0), 32'd0);
    idle("t2_after", 2);

    // 3: good 5A, then missing end strobe on bit7
    send_word("t3a", 8'h5A);
    w = 8'h77;
    e0 = n_err; v0 = n_valid;
    for (int i = 0; i < W; i++) cyc("t3b", i == 0, w[i], 1'b0);
    chk("t3_err", 32'(frame_err), 32'd1);
    chk("t3_hold", 32'(parallel_out), 32'h5A);
    chk("t3_novalid", 32'(n_valid - v0), 32'd0);
    idle("t3_after", 2);

    // 4: abort by restart at bit4, then a full 81
    w = 8'hE6;
    e0 = n_err;
    for (int i = 0; i < 4; i++) cyc("t4a", i == 0, w[i], 1'b0);
    send_word("t4b", 8'h81);
    chk("t4_nerr", 32'(n_err - e0), 32'd1);
    chk("t4_word", 32'(parallel_out), 32'h81);
    chk("t4_valid", 32'(parallel_valid), 32'd1);
    idle("t4_after", 1);

    // 5: early end at bit2, then stray end while idle
    e0 = n_err;
    w = 8'h3B;
    for (int i = 0; i < 3; i++) cyc("t5a", i == 0, w[i], i == 2);
    idle("t5_gap", 2);
    cyc("t5_stray", 1'b0, 1'b1, 1'b1);
    idle("t5_after", 1);
    chk("t5_nerr", 32'(n_err - e0), 32'd2);
    chk("t5_hold", 32'(parallel_out), 32'h81);

    // 6: reset at bit5 for two cycles, then full 0F
    w = 8'hAA;
    for (int i = 0; i < 5; i++) cyc("t6a", i == 0, w[i], 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_outputs("t6_rst0");
    for (int i = 0; i < 2; i++) begin
      serial_start = 1'b0; serial_in = w[5 + i]; serial_end = (i == 1);
      @(posedge clk);
      #1;
      cmp_outputs("t6_rst");
    end
    rst_n = 1'b1;
    v0 = n_valid; e0 = n_err;
    idle("t6_gap", 1);
    send_word("t6b", 8'h0F);
    chk("t6_word", 32'(parallel_out), 32'h0F);
    chk("t6_nvalid", 32'(n_valid - v0), 32'd1);
    chk("t6_nerr", 32'(n_err - e0), 32'd0);

    // random streams with occasional restarts, flipped end strobes and stray ends
    tv = 0;
    for (int f = 0; f < 150; f++) begin
      w = W'($urandom);
      for (int i = 0; i < W; i++)
        cyc("rnd", (i == 0) || ($urandom_range(0, 40) == 0), w[i],
            (i == W - 1) ^ ($urandom_range(0, 25) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--)
        cyc("rnd_gap", 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      tv++;
    end
    chk("rnd_frames", 32'(tv), 32'd150);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
